potato1_exec_ctrl: RTL and testbench
====================================

# potato1_exec_ctrl

Execution controller that closes the loop around the Potato-1 core. It owns the program counter, data pointer and data tape, and feeds the core its instruction, zero flag and I/O-wait inputs. It decodes the core's 8-bit command bus and sequences PUT/GET transfers over a valid/ready host port. After reset it clears the tape and holds the core in reset until the clear finishes.

## Interface
- PC_W, 8, program counter / program address width
- TAPE_DEPTH, 16, number of 8-bit tape cells (power of two, ≥2)
- X_W, $clog2(TAPE_DEPTH), data pointer width
- Clock  in  1  clock (core shares it)
- Reset_n  in  1  reset, asynchronous, active-low
- cmd  in  8  core command bus: [0]PC_INC [1]PC_DEC [2]X_INC [3]X_DEC [4]A_INC [5]A_DEC [6]PUT [7]GET
- prog_addr  out  PC_W  program ROM address (= PC register)
- prog_data  in  4  ROM opcode at prog_addr (combinational ROM)
- core_instr  out  4  to core io_in[7:4]; = prog_data, forced 4'b1111 while clearing
- core_zero  out  1  to core io_in[3]; tape[X]==0
- core_io_wait  out  1  to core io_in[2]
- core_rst_n  out  1  to core io_in[1]; 0 while clearing
- out_data  out  8  PUT value
- out_valid  out  1  PUT pending
- out_ready  in  1  host accepts PUT
- in_data  in  8  GET value
- in_valid  in  1  host offers GET
- in_ready  out  1  GET pending

## Operation
- FSM states: CLEAR, IDLE, PUT_WAIT, GET_WAIT. All registers are updated on posedge Clock.
- Reset (any time, including mid-transfer) forces state=CLEAR, PC=0, X=0, clr_idx=0, out_valid=0, in_ready=0, out_data=0, core_rst_n=0.
- CLEAR: writes tape[clr_idx]=0 and increments clr_idx. After the write to index TAPE_DEPTH-1, the next state is IDLE. In this state cmd is ignored.
- core_rst_n is 1 only outside CLEAR, so the core leaves reset after exactly TAPE_DEPTH cycles.
- IDLE, per edge, all fields applied independently:
  - PC += PC_INC − PC_DEC, modulo 2^PC_W.
  - X += X_INC − X_DEC, modulo TAPE_DEPTH.
  - tape[X_old] += A_INC − A_DEC, modulo 256. The cell addressed is the one at X before any pointer update in the same edge.
  - If both INC and DEC of a field are set, that field is unchanged.
  - PUT (priority over GET if both set): out_data ← tape[X_old] after the A update, out_valid ← 1, go to PUT_WAIT.
  - GET: in_ready ← 1, go to GET_WAIT.
- PUT_WAIT: on out_valid && out_ready, clear out_valid and go to IDLE.
- GET_WAIT: on in_valid && in_ready, write tape[X] ← in_data, clear in_ready and go to IDLE.
- In the WAIT states, cmd is ignored entirely. While the core is waiting it re-presents the held PUT/GET with PC bits 0.
- core_io_wait (combinational) =
  - (IDLE && (cmd[6]||cmd[7])), or
  - (PUT_WAIT && !out_ready), or
  - (GET_WAIT && !in_valid).
- core_zero (combinational) = (tape[X]==0) from registered state.

## Timing
- Command sampled at edge n takes effect in registers at edge n. The new prog_addr, core_instr and core_zero are visible after edge n, ready for the core's sampling at edge n+1.
- PUT: out_valid rises the edge after the PUT command. Minimum PUT occupancy is 2 cycles, when out_ready is already high.
- core_io_wait drops in the same cycle the handshake completes. The core therefore samples IOWait=0 on the completing edge and issues its next command one cycle later.
- GET data is written to the tape on the completing edge. core_zero reflects the new value from the next cycle.
- out_data is stable while out_valid=1.
- in_ready and out_valid are never high simultaneously.

## Structure
- Shared package potato1_pkg holds:
  - command bit indices (CMD_PC_INC…CMD_GET);
  - opcode constants (OP_HALT=4'b1111 etc.);
  - FSM state enum.
- The core's command encoding must import the same constants.
- One sub-module: potato1_tape, a TAPE_DEPTH×8 register file with async read, one sync write port and an inc/dec/load modify path. No reset on its storage; clearing is done by the FSM.

## Test plan
- Reset with TAPE_DEPTH=16: core_rst_n=0 for 16 cycles; afterwards every cell reads 0, core_zero=1, prog_addr=0.
- cmd=0x11 (PC_INC, A_INC) ×3, then 0x08 (X_DEC): tape[0]=3, X=15 (wrap), PC=3, core_zero=1.
- A_DEC on a 0 cell → cell=255, core_zero=0. PC_DEC at PC=0 → prog_addr=2^PC_W−1.
- PUT with tape[X]=0x2A and out_ready held low 5 cycles: out_valid=1, out_data=0x2A, core_io_wait=1 throughout. Repeated cmd during the wait does not retrigger. The transfer completes with exactly one beat.
- GET with in_data=0x00 after 3 cycles of in_valid=0 following tape[X]=7: core_zero goes 0→1 the cycle after the handshake; in_ready deasserts.
- Reset_n pulsed low during PUT_WAIT: out_valid=0 immediately, state=CLEAR, tape re-cleared, core held in reset again for 16 cycles.

Source files
------------

// File: rtl/potato1_pkg.sv
// -----------------------------------------------------------------------------
// potato1_pkg
// Shared definitions for the Potato-1 core and its execution controller:
//   - bit positions of the core's 8-bit command bus
//   - 4-bit program opcodes (the core decodes these, the controller forces HALT)
//   - execution controller FSM states and tape write operations
// -----------------------------------------------------------------------------
package potato1_pkg;

    // Command bus bit indices
    localparam int CMD_PC_INC = 0;
    localparam int CMD_PC_DEC = 1;
    localparam int CMD_X_INC  = 2;
    localparam int CMD_X_DEC  = 3;
    localparam int CMD_A_INC  = 4;
    localparam int CMD_A_DEC  = 5;
    localparam int CMD_PUT    = 6;
    localparam int CMD_GET    = 7;

    // Program opcodes
    localparam logic [3:0] OP_NOP      = 4'b0000;
    localparam logic [3:0] OP_X_INC    = 4'b0001;
    localparam logic [3:0] OP_X_DEC    = 4'b0010;
    localparam logic [3:0] OP_A_INC    = 4'b0011;
    localparam logic [3:0] OP_A_DEC    = 4'b0100;
    localparam logic [3:0] OP_PUT      = 4'b0101;
    localparam logic [3:0] OP_GET      = 4'b0110;
    localparam logic [3:0] OP_LOOP_BEG = 4'b0111;
    localparam logic [3:0] OP_LOOP_END = 4'b1000;
    localparam logic [3:0] OP_HALT     = 4'b1111;

    // Execution controller states
    typedef enum logic [1:0] {
        ST_CLEAR    = 2'd0,
        ST_IDLE     = 2'd1,
        ST_PUT_WAIT = 2'd2,
        ST_GET_WAIT = 2'd3
    } exec_state_t;

    // Tape write source: modify the addressed cell, or load a fresh value
    typedef enum logic {
        TAPE_MODIFY = 1'b0,
        TAPE_LOAD   = 1'b1
    } tape_op_t;

endpackage

// File: rtl/potato1_tape.sv
// -----------------------------------------------------------------------------
// potato1_tape
// DEPTH x 8-bit data tape. Asynchronous read port, one synchronous write port.
// The write value is either load_data or the addressed cell +1/-1 (unchanged
// when inc and dec are both set); that value is also exported so the caller
// can capture the post-modify cell contents in the same cycle.
// Ports:
//   Clock            clock
//   rd_addr/rd_data  async read port
//   wr_en/wr_addr    write strobe and address
//   wr_op            TAPE_MODIFY (inc/dec) or TAPE_LOAD (load_data)
//   load_data        value written for TAPE_LOAD
//   inc/dec          modify controls
//   wr_value         value that a write this cycle would store
// -----------------------------------------------------------------------------
module potato1_tape
    import potato1_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clock,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  tape_op_t      wr_op,
    input  logic [7:0]    load_data,
    input  logic          inc,
    input  logic          dec,
    output logic [7:0]    wr_value
);

    logic [7:0] mem [DEPTH];

    assign rd_data = mem[rd_addr];

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        wr_value = mem[wr_addr];
        if (wr_op == TAPE_LOAD) begin
            wr_value = load_data;
        end else if (inc && !dec) begin
            wr_value = mem[wr_addr] + 8'd1;
        end else if (dec && !inc) begin
            wr_value = mem[wr_addr] - 8'd1;
        end
    end

    // NOTE: storage has no reset; it stays a plain register file and the controller clears it by writing zeros.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_value;
        end
    end

endmodule

// File: rtl/potato1_exec_ctrl.sv
// -----------------------------------------------------------------------------
// potato1_exec_ctrl
// Execution controller around the Potato-1 core. Owns PC, data pointer X and
// the data tape; decodes the core command bus; runs PUT/GET handshakes on a
// valid/ready host port; clears the tape after reset while holding the core
// in reset.
// Ports:
//   Clock, Reset_n        clock, async active-low reset
//   cmd                   core command bus (bit indices in potato1_pkg)
//   prog_addr/prog_data   program ROM address (PC) and combinational opcode
//   core_instr            opcode to core, HALT while clearing
//   core_zero             tape[X] == 0
//   core_io_wait          core must stall
//   core_rst_n            core reset, low while clearing
//   out_data/valid/ready  PUT channel to host
//   in_data/valid/ready   GET channel from host
// -----------------------------------------------------------------------------
module potato1_exec_ctrl
    import potato1_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int TAPE_DEPTH = 16,
    parameter int X_W        = $clog2(TAPE_DEPTH)
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic [7:0]      cmd,
    output logic [PC_W-1:0] prog_addr,
    input  logic [3:0]      prog_data,
    output logic [3:0]      core_instr,
    output logic            core_zero,
    output logic            core_io_wait,
    output logic            core_rst_n,
    output logic [7:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready
);

    exec_state_t     state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [X_W-1:0]  clr_idx_q, clr_idx_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic [7:0]      tape_rd_data;
    logic            tape_wr_en;
    logic [X_W-1:0]  tape_wr_addr;
    tape_op_t        tape_op;
    logic [7:0]      tape_load_data;
    logic [7:0]      tape_wr_value;

    // Tape write controls. In IDLE the modify path works on the cell at the
    // current (pre-update) X, which is also the cell a PUT reports.
    assign tape_wr_addr   = (state_q == ST_CLEAR) ? clr_idx_q : x_q;
    assign tape_op        = (state_q == ST_IDLE) ? TAPE_MODIFY : TAPE_LOAD;
    assign tape_load_data = (state_q == ST_GET_WAIT) ? in_data : 8'd0;
    assign tape_wr_en     = (state_q == ST_CLEAR)
                         || ((state_q == ST_IDLE) && (cmd[CMD_A_INC] || cmd[CMD_A_DEC]))
                         || ((state_q == ST_GET_WAIT) && in_valid);

    potato1_tape #(
        .DEPTH (TAPE_DEPTH),
        .AW    (X_W)
    ) u_tape (
        .Clock     (Clock),
        .rd_addr   (x_q),
        .rd_data   (tape_rd_data),
        .wr_en     (tape_wr_en),
        .wr_addr   (tape_wr_addr),
        .wr_op     (tape_op),
        .load_data (tape_load_data),
        .inc       (cmd[CMD_A_INC]),
        .dec       (cmd[CMD_A_DEC]),
        .wr_value  (tape_wr_value)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        x_d         = x_q;
        clr_idx_d   = clr_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        unique case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + X_W'(1);
                if (clr_idx_q == X_W'(TAPE_DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // INC and DEC of a field cancel when both set.
                pc_d = pc_q + PC_W'(cmd[CMD_PC_INC]) - PC_W'(cmd[CMD_PC_DEC]);
                x_d  = x_q + X_W'(cmd[CMD_X_INC]) - X_W'(cmd[CMD_X_DEC]);
                if (cmd[CMD_PUT]) begin
                    out_data_d  = tape_wr_value;
                    out_valid_d = 1'b1;
                    state_d     = ST_PUT_WAIT;
                end else if (cmd[CMD_GET]) begin
                    in_ready_d = 1'b1;
                    state_d    = ST_GET_WAIT;
                end
            end
            ST_PUT_WAIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_GET_WAIT: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_CLEAR;
            pc_q        <= '0;
            x_q         <= '0;
            clr_idx_q   <= '0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            x_q         <= x_d;
            clr_idx_q   <= clr_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign prog_addr    = pc_q;
    assign core_rst_n   = (state_q != ST_CLEAR);
    assign core_instr   = core_rst_n ? prog_data : OP_HALT;
    assign core_zero    = (tape_rd_data == 8'd0);
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign in_ready     = in_ready_q;
    assign core_io_wait = ((state_q == ST_IDLE) && (cmd[CMD_PUT] || cmd[CMD_GET]))
                       || ((state_q == ST_PUT_WAIT) && !out_ready)
                       || ((state_q == ST_GET_WAIT) && !in_valid);

endmodule

// File: tb/tb_potato1_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_potato1_exec_ctrl
// Self-checking bench: directed scenarios followed by random commands, with a
// reference model of PC, X and the tape. PUT values are queued when issued and
// a negedge monitor compares them against the DUT while out_valid is high.
// -----------------------------------------------------------------------------
module tb_potato1_exec_ctrl;
    import potato1_pkg::*;

    localparam int PC_W  = 8;
    localparam int DEPTH = 16;
    localparam int XW    = 4;

    logic            Clock   = 1'b0;
    logic            Reset_n = 1'b1;
    logic [7:0]      cmd     = 8'd0;
    logic [PC_W-1:0] prog_addr;
    logic [3:0]      prog_data;
    logic [3:0]      core_instr;
    logic            core_zero;
    logic            core_io_wait;
    logic            core_rst_n;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [7:0]      in_data   = 8'd0;
    logic            in_valid  = 1'b0;
    logic            in_ready;

    logic [3:0] rom [256];
    assign prog_data = rom[prog_addr];

    potato1_exec_ctrl #(
        .PC_W       (PC_W),
        .TAPE_DEPTH (DEPTH),
        .X_W        (XW)
    ) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .cmd          (cmd),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .core_instr   (core_instr),
        .core_zero    (core_zero),
        .core_io_wait (core_io_wait),
        .core_rst_n   (core_rst_n),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready)
    );

    always #5 Clock = ~Clock;

    // Reference model state
    int         m_pc;
    int         m_x;
    int         m_tape [DEPTH];
    logic [7:0] exp_q [$];
    int         beats;
    int         checks;
    int         errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 0;
        m_x  = 0;
        for (int i = 0; i < DEPTH; i++) m_tape[i] = 0;
    endfunction

    // Apply one IDLE command's field updates; returns the addressed cell
    // after its A update (the value a PUT would report).
    function automatic int model_idle(input logic [7:0] c);
        int pi = c[CMD_PC_INC] ? 1 : 0;
        int pd = c[CMD_PC_DEC] ? 1 : 0;
        int xi = c[CMD_X_INC]  ? 1 : 0;
        int xd = c[CMD_X_DEC]  ? 1 : 0;
        int ai = c[CMD_A_INC]  ? 1 : 0;
        int ad = c[CMD_A_DEC]  ? 1 : 0;
        int v;
        m_tape[m_x] = (m_tape[m_x] + ai - ad + 256) % 256;
        v = m_tape[m_x];
        m_pc = (m_pc + pi - pd + 256) % 256;
        m_x  = (m_x + xi - xd + DEPTH) % DEPTH;
        return v;
    endfunction

    // Inputs change at posedge+2; outputs are checked at posedge+3 or later.
    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic check_idle_outputs(input string tag);
        #1;
        check({tag, "_prog_addr"},  prog_addr, m_pc);
        check({tag, "_core_zero"},  core_zero, (m_tape[m_x] == 0));
        check({tag, "_core_instr"}, core_instr, rom[m_pc]);
        check({tag, "_core_rst_n"}, core_rst_n, 1);
        check({tag, "_out_valid"},  out_valid, 0);
        check({tag, "_in_ready"},   in_ready, 0);
        check({tag, "_io_wait"},    core_io_wait, 0);
    endtask

    task automatic issue(input logic [7:0] c);
        int v;
        cmd = c;
        tick();
        v = model_idle(c);
        cmd = 8'd0;
        check_idle_outputs("issue");
    endtask

    task automatic do_put(input logic [7:0] c, input int delay);
        int b0;
        int v;
        b0 = beats;
        cmd = c;
        out_ready = (delay == 0);
        #1;
        check("put_issue_io_wait", core_io_wait, 1);
        tick();
        v = model_idle(c);
        exp_q.push_back(8'(v));
        cmd = c & 8'hFC;
        for (int i = 0; i < delay; i++) begin
            #1;
            check("put_wait_valid", out_valid, 1);
            check("put_wait_io_wait", core_io_wait, 1);
            check("put_wait_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("put_done_io_wait", core_io_wait, 0);
        tick();
        out_ready = 1'b0;
        cmd = 8'd0;
        #1;
        check("put_single_beat", beats, b0 + 1);
        check_idle_outputs("put");
    endtask

    task automatic do_get(input logic [7:0] c, input int delay, input logic [7:0] data);
        int v;
        cmd = c;
        in_valid = 1'b0;
        #1;
        check("get_issue_io_wait", core_io_wait, 1);
        tick();
        v = model_idle(c);
        cmd = c & 8'hFC;
        for (int i = 0; i < delay; i++) begin
            #1;
            check("get_wait_ready", in_ready, 1);
            check("get_wait_io_wait", core_io_wait, 1);
            check("get_wait_out_valid", out_valid, 0);
            check("get_wait_zero", core_zero, (m_tape[m_x] == 0));
            tick();
        end
        in_valid = 1'b1;
        in_data  = data;
        #1;
        check("get_done_io_wait", core_io_wait, 0);
        tick();
        m_tape[m_x] = data;
        in_valid = 1'b0;
        cmd = 8'd0;
        check_idle_outputs("get");
    endtask

    task automatic reset_and_clear();
        int n;
        Reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_prog_addr", prog_addr, 0);
        check("rst_core_instr", core_instr, OP_HALT);
        tick();
        tick();
        cmd = 8'h15;    // must be ignored while clearing
        Reset_n = 1'b1;
        n = 0;
        while (n < 64) begin
            #1;
            if (core_rst_n) break;
            n++;
            tick();
        end
        check("clear_cycles", n, DEPTH);
        model_reset();
        cmd = 8'd0;
        check_idle_outputs("after_clear");
        for (int i = 0; i < DEPTH; i++) issue(8'h04);   // walk X over every cell
    endtask

    // Monitor: compares out_data against the queued PUT value every cycle it
    // is offered, and retires it on the handshake.
    always @(negedge Clock) begin
        if (Reset_n && out_valid) begin
            check("put_queue_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                check("put_out_data", out_data, exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        checks = 0;
        errors = 0;
        beats  = 0;
        for (int i = 0; i < 256; i++) rom[i] = 4'($urandom_range(0, 14));
        model_reset();
        #1;

        reset_and_clear();

        // Tape[0] = 3 via combined PC/A increments, then X wraps to 15
        for (int i = 0; i < 3; i++) issue(8'h11);
        issue(8'h08);
        #1;
        check("x_wrap_zero", core_zero, 1);
        check("pc_three", prog_addr, 3);

        // A_DEC on a zero cell wraps to 255
        issue(8'h20);
        check("a_dec_wrap_zero", core_zero, 0);
        do_put(8'h40, 0);

        // PC_DEC from 3 down past 0
        for (int i = 0; i < 4; i++) issue(8'h02);
        check("pc_wrap", prog_addr, 8'hFF);

        // X -> 1, cell = 0x2A, PUT with out_ready low for 5 cycles
        issue(8'h04);
        issue(8'h04);
        for (int i = 0; i < 42; i++) issue(8'h10);
        do_put(8'h40, 5);

        // X -> 2, cell = 7, GET of 0 after 3 idle cycles
        issue(8'h04);
        for (int i = 0; i < 7; i++) issue(8'h10);
        check("get_pre_zero", core_zero, 0);
        do_get(8'h80, 3, 8'h00);
        check("get_post_zero", core_zero, 1);

        // Cancelling pairs, PUT priority over GET
        issue(8'h3F);
        do_put(8'hC0, 1);
        do_put(8'h5D, 2);

        // Randomized commands
        for (int k = 0; k < 300; k++) begin
            c = 8'($urandom_range(0, 255));
            if (c[CMD_PUT]) begin
                do_put(c, $urandom_range(0, 4));
            end else if (c[CMD_GET]) begin
                do_get(c, $urandom_range(0, 3),
                       ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255)));
            end else begin
                issue(c);
            end
        end

        // Reset in the middle of a PUT wait on a non-zero cell
        cmd = 8'h50;
        out_ready = 1'b0;
        tick();
        exp_q.push_back(8'(model_idle(8'h50)));
        cmd = 8'h40;
        tick();
        tick();
        #1;
        check("mid_put_valid", out_valid, 1);
        reset_and_clear();

        // Controller is usable again after the re-clear
        issue(8'h30);
        issue(8'h10);
        do_put(8'h40, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
